// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage with a req/ack data-memory port
// and a registered MEM/WB bundle; stalls upstream while an access runs.
module memory_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exValid,
   input  logic              exMemRead,
   input  logic              exMemWrite,
   input  logic              exRegWrite,
   input  logic              exMemToReg,
   input  logic [DATA_W-1:0] exAluResult,
   input  logic [DATA_W-1:0] exWriteData,
   input  logic [2:0]        exRd,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memAck,
   output logic              stall,
   output logic              wbValid,
   output logic              wbRegWrite,
   output logic [2:0]        wbRd,
   output logic [DATA_W-1:0] wbData
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t state_q, state_d;

   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic [2:0]        rd_q, rd_d;
   logic              reg_write_q, reg_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic [DATA_W-1:0] alu_q, alu_d;

   logic              wb_valid_q, wb_valid_d;
   logic              wb_reg_write_q, wb_reg_write_d;
   logic [2:0]        wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic mem_op;

   assign mem_op = exValid & (exMemRead | exMemWrite);

   // Next state: latch a memory op, run the access, or pass ALU results on
   always_comb begin
      state_d        = state_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      rd_d           = rd_q;
      reg_write_d    = reg_write_q;
      mem_to_reg_d   = mem_to_reg_q;
      alu_d          = alu_q;
      wb_valid_d     = wb_valid_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      unique case (state_q)
         IDLE: begin
            if (mem_op) begin
               state_d      = ACCESS;
               mem_req_d    = 1'b1;
               mem_we_d     = exMemWrite;
               mem_addr_d   = exAluResult[ADDR_W-1:0];
               mem_wdata_d  = exWriteData;
               rd_d         = exRd;
               // a read+write op is treated as a store with no register write
               reg_write_d  = exRegWrite & ~(exMemRead & exMemWrite);
               mem_to_reg_d = exMemToReg;
               alu_d        = exAluResult;
               wb_valid_d   = 1'b0;
            end else begin
               wb_valid_d     = exValid;
               wb_reg_write_d = exValid & exRegWrite;
               wb_rd_d        = exRd;
               wb_data_d      = exAluResult;
            end
         end
         ACCESS: begin
            if (memAck) begin
               state_d        = IDLE;
               mem_req_d      = 1'b0;
               wb_valid_d     = 1'b1;
               wb_reg_write_d = reg_write_q;
               wb_rd_d        = rd_q;
               // stores never forward read data
               wb_data_d      = (mem_to_reg_q & ~mem_we_q) ? memRdata : alu_q;
            end else begin
               wb_valid_d = 1'b0;
            end
         end
      endcase
   end

   assign stall = ((state_q == IDLE) & mem_op) |
                  ((state_q == ACCESS) & ~memAck);

   // State and registered outputs; reset abandons any access in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         rd_q           <= '0;
         reg_write_q    <= 1'b0;
         mem_to_reg_q   <= 1'b0;
         alu_q          <= '0;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
      end else begin
         state_q        <= state_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         rd_q           <= rd_d;
         reg_write_q    <= reg_write_d;
         mem_to_reg_q   <= mem_to_reg_d;
         alu_q          <= alu_d;
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
      end
   end

   assign memReq     = mem_req_q;
   assign memWe      = mem_we_q;
   assign memAddr    = mem_addr_q;
   assign memWdata   = mem_wdata_q;
   assign wbValid    = wb_valid_q;
   assign wbRegWrite = wb_reg_write_q;
   assign wbRd       = wb_rd_q;
   assign wbData     = wb_data_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the 5-stage pipeline. It consumes the Execute stage's ALU result and control bits, and performs data-memory loads and stores through a req/ack handshake to an external word-addressed data memory. It stalls the upstream pipeline while an access is outstanding. It registers the write-back bundle (MEM/WB) for the Write-Back stage.

## Interface
Parameters:
- DATA_W, 16, datapath and memory word width
- ADDR_W, 16, memory address width; the address is taken from exAluResult[ADDR_W-1:0]

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-low
- exValid  in  1  the Execute-side bundle holds a real instruction
- exMemRead  in  1  load
- exMemWrite  in  1  store
- exRegWrite  in  1  instruction writes the register file
- exMemToReg  in  1  write-back data selects memory data (1) or ALU result (0)
- exAluResult  in  DATA_W  ALU output; used as the address for loads and stores
- exWriteData  in  DATA_W  store data
- exRd  in  3  destination register
- memReq  out  1  access request to the data memory
- memWe  out  1  1 = write, 0 = read; valid while memReq = 1
- memAddr  out  ADDR_W  access address
- memWdata  out  DATA_W  store data
- memRdata  in  DATA_W  read data; valid in the cycle memAck = 1
- memAck  in  1  access complete
- stall  out  1  hold the upstream stages (combinational)
- wbValid, wbRegWrite  out  1 each  MEM/WB control
- wbRd  out  3  MEM/WB destination register
- wbData  out  DATA_W  MEM/WB write-back data

## Operation
FSM states: IDLE and ACCESS.

IDLE:
- memOp = exValid & (exMemRead | exMemWrite).
- If memOp = 1:
  - latch exRd, exRegWrite, exMemToReg, exAluResult, exWriteData and the write flag (we = exMemWrite);
  - drive wbValid to 0 on that edge (bubble);
  - go to ACCESS.
- Else:
  - MEM/WB loads pass-through values: wbValid = exValid, wbRegWrite = exValid & exRegWrite, wbRd = exRd, wbData = exAluResult.

ACCESS:
- memReq = 1. memWe, memAddr and memWdata come from the latched values and stay constant until the ack is sampled.
- On memAck = 1:
  - MEM/WB loads wbValid = 1, wbRegWrite = latched regWrite, wbRd = latched rd;
  - wbData = memRdata if latched memToReg, else the latched ALU result;
  - go to IDLE.
- While memAck = 0: wbValid = 0 and the state stays ACCESS.

stall:
- stall = (IDLE & memOp) | (ACCESS & ~memAck).
- Upstream holds its bundle while stall = 1. The bundle advances on the ack edge.

Boundary rules:
- exMemRead and exMemWrite both 1: a store is performed (memWe = 1) and the wbRegWrite result is forced to 0.
- memAck in IDLE is ignored.
- memRdata is ignored for stores.
- exValid = 0 with mem bits set is not a memory op: no request, wbValid = 0.
- The memory is never given two overlapping requests: a new request starts no earlier than one cycle after an ack.

## Timing
- Reset (rst = 0 at a posedge) values: state IDLE, memReq 0, memWe 0, memAddr 0, memWdata 0, wbValid 0, wbRegWrite 0, wbRd 0, wbData 0.
- Reset in ACCESS abandons the access: memReq is 0 from the following cycle and no write-back is produced.
- stall is combinational, so during reset it follows the IDLE equation.
- Non-memory instruction: latency 1 cycle (EX bundle at cycle n gives MEM/WB at cycle n+1), with no stall.
- Memory instruction presented at cycle n:
  - memReq is 1 from cycle n+1.
  - If memAck first rises at cycle n+k (k ≥ 1): wbValid = 1 at cycle n+k+1.
  - stall = 1 for cycles n..n+k-1 and 0 at n+k.
  - The next EX bundle is seen at n+k+1.
- Minimum load/store latency is 2 cycles (k = 1).
- memReq, memWe, memAddr and memWdata are registered outputs, with no combinational path from memAck.
- Back-to-back memory ops: the second sees IDLE at n+k+1, so memReq drops for exactly one cycle between them.

## Test plan
- Reset: hold rst = 0 for 2 cycles with exValid = 1 and memOp. Require all outputs 0, memReq 0 and stall = 1 (IDLE equation). After release, the request starts normally.
- ALU pass-through: exValid = 1, exRegWrite = 1, exRd = 5, exAluResult = 0x1234, no mem bits. Next cycle require wbValid = 1, wbRegWrite = 1, wbRd = 5, wbData = 0x1234, and stall = 0 throughout.
- Load, ack after 3 cycles:
  - Stimulus: exMemRead = 1, exMemToReg = 1, exRegWrite = 1, exRd = 2, exAluResult = 0x0040; memAck = 1 at cycle n+3 with memRdata = 0xBEEF.
  - Require memReq = 1, memWe = 0, memAddr = 0x0040 for cycles n+1..n+3; stall = 1 for n..n+2 and 0 at n+3; at n+4, wbValid = 1, wbRd = 2, wbData = 0xBEEF.
- Store with immediate ack:
  - Stimulus: exMemWrite = 1, exAluResult = 0x0010, exWriteData = 0x00FF; memAck = 1 at n+1.
  - Require memWe = 1, memWdata = 0x00FF, memAddr = 0x0010 at n+1, and wbRegWrite = 0 at n+2.
  - Repeat with exMemRead = exMemWrite = 1 and exRegWrite = 1: require memWe = 1 and wbRegWrite = 0.
- Back-to-back loads with addresses 0x0001 then 0x0002, each acked after 1 cycle. Require memReq drops for exactly 1 cycle between them and the two wbData values arrive in order.
- Reset mid-access: assert rst = 0 during ACCESS before memAck. Require memReq = 0 the next cycle and no wbValid pulse; then assert memAck = 1 while IDLE and require no state change.
